// File: rtl/regset_arbiter_if.sv
// Bus between the two requesters, the arbiter and the 8 x 4-bit regset.
interface regset_arbiter_if #(
    parameter int DW = 4,
    parameter int AW = 3
);
    logic          Req0, Wr0, Gnt0, Done0;
    logic [AW-1:0] Addr0;
    logic [DW-1:0] Wdata0, Rdata0;
    logic          Req1, Wr1, Gnt1, Done1;
    logic [AW-1:0] Addr1;
    logic [DW-1:0] Wdata1, Rdata1;
    logic          RS_RW;
    logic [AW-1:0] RS_Address;
    logic [DW-1:0] RS_Data_in, RS_Data_out;

    // arbiter side
    modport slave (
        input  Req0, Wr0, Addr0, Wdata0, Req1, Wr1, Addr1, Wdata1, RS_Data_out,
        output Gnt0, Done0, Rdata0, Gnt1, Done1, Rdata1, RS_RW, RS_Address, RS_Data_in
    );

    // requesters / regset side
    modport master (
        output Req0, Wr0, Addr0, Wdata0, Req1, Wr1, Addr1, Wdata1, RS_Data_out,
        input  Gnt0, Done0, Rdata0, Gnt1, Done1, Rdata1, RS_RW, RS_Address, RS_Data_in
    );
endinterface

// File: rtl/regset_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the negedge regset.
// One access per two cycles: grant edge -> ACC cycle (regset acts on its negedge)
// -> completion edge (Done pulse, read capture).
module regset_arbiter #(
    parameter int DW = 4,
    parameter int AW = 3
) (
    input  logic            Clk,
    input  logic            Rst,
    regset_arbiter_if.slave bus
);
    typedef enum logic {IDLE, ACC} state_t;

    state_t        state, state_nxt;
    logic          last;      // 1 = requester 1 was granted last
    logic          cur;       // current owner
    logic          wr_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic          done0_q, done1_q;
    logic [DW-1:0] rdata0_q, rdata1_q;
    logic          any_req, pick1;

    // Winner select: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        any_req = bus.Req0 | bus.Req1;
        pick1   = bus.Req1 & (~bus.Req0 | ~last);
    end

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: ACC always lasts exactly one cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = ACC;
            ACC:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Command latch: fields are sampled only on the grant edge and held afterwards
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            last    <= 1'b1;
            cur     <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && any_req) begin
            cur     <= pick1;
            last    <= pick1;
            wr_q    <= pick1 ? bus.Wr1    : bus.Wr0;
            addr_q  <= pick1 ? bus.Addr1  : bus.Addr0;
            wdata_q <= pick1 ? bus.Wdata1 : bus.Wdata0;
        end
    end

    // Completion: Done pulse and read capture on the edge leaving ACC
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            done0_q <= (state == ACC) & ~cur;
            done1_q <= (state == ACC) &  cur;
            if (state == ACC && !wr_q) begin
                if (cur) rdata1_q <= bus.RS_Data_out;
                else     rdata0_q <= bus.RS_Data_out;
            end
        end
    end

    // Outputs: RW drops to 0 only inside a write's ACC cycle, so reset clears it at once
    always_comb begin
        bus.Gnt0       = (state == ACC) & ~cur;
        bus.Gnt1       = (state == ACC) &  cur;
        bus.Done0      = done0_q;
        bus.Done1      = done1_q;
        bus.Rdata0     = rdata0_q;
        bus.Rdata1     = rdata1_q;
        bus.RS_RW      = ~((state == ACC) & wr_q);
        bus.RS_Address = addr_q;
        bus.RS_Data_in = wdata_q;
    end
endmodule

// File: tb/tb_regset_arbiter.sv
// Directed bench for regset_arbiter with a behavioural negedge regset model.
module tb_regset_arbiter;
    logic Clk = 1'b0;
    logic Rst = 1'b1;

    regset_arbiter_if #(.DW(4), .AW(3)) bus ();

    regset_arbiter #(.DW(4), .AW(3)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    // Regset model: read or write on every negedge, Data_out Z after a write
    logic [3:0] mem [8] = '{default: 4'h0};
    logic [3:0] rs_dout = 4'h0;
    int         wr_cnt   = 0;
    int         done_cnt = 0;
    assign bus.RS_Data_out = rs_dout;

    always @(negedge Clk) begin
        if (bus.RS_RW) rs_dout <= mem[bus.RS_Address];
        else begin
            mem[bus.RS_Address] <= bus.RS_Data_in;
            rs_dout <= 'z;
            wr_cnt  <= wr_cnt + 1;
        end
        done_cnt <= done_cnt + int'(bus.Done0) + int'(bus.Done1);
    end

    typedef struct {
        int         port;
        logic       wr;
        logic [2:0] addr;
        logic [3:0] data;   // write data, or expected read data
    } vec_t;

    vec_t       vec [20];
    logic [3:0] exp_rd [2];
    int         tests = 0;
    int         fails = 0;

    task automatic chk(input string nm, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // One isolated access with fixed latency checks
    task automatic do_access(input string nm, input int p, input logic wr,
                             input logic [2:0] a, input logic [3:0] d);
        int w0;
        w0 = wr_cnt;
        @(negedge Clk);
        if (p == 0) begin
            bus.Req0 = 1'b1; bus.Wr0 = wr; bus.Addr0 = a; bus.Wdata0 = d;
        end else begin
            bus.Req1 = 1'b1; bus.Wr1 = wr; bus.Addr1 = a; bus.Wdata1 = d;
        end
        @(posedge Clk); #1;
        chk({nm, ".gnt"},       int'(p == 0 ? bus.Gnt0 : bus.Gnt1), 1);
        chk({nm, ".gnt_other"}, int'(p == 0 ? bus.Gnt1 : bus.Gnt0), 0);
        chk({nm, ".rs_rw"},     int'(bus.RS_RW), int'(!wr));
        chk({nm, ".rs_addr"},   int'(bus.RS_Address), int'(a));
        if (wr) chk({nm, ".rs_din"}, int'(bus.RS_Data_in), int'(d));
        @(posedge Clk); #1;
        chk({nm, ".done"},       int'(p == 0 ? bus.Done0 : bus.Done1), 1);
        chk({nm, ".done_other"}, int'(p == 0 ? bus.Done1 : bus.Done0), 0);
        chk({nm, ".gnt_off"},    int'(bus.Gnt0 | bus.Gnt1), 0);
        chk({nm, ".rw_idle"},    int'(bus.RS_RW), 1);
        if (!wr) exp_rd[p] = d;
        chk({nm, ".rdata0"}, int'(bus.Rdata0), int'(exp_rd[0]));
        chk({nm, ".rdata1"}, int'(bus.Rdata1), int'(exp_rd[1]));
        bus.Req0 = 1'b0; bus.Req1 = 1'b0;
        @(posedge Clk); #1;
        chk({nm, ".done_end"}, int'(bus.Done0 | bus.Done1), 0);
        chk({nm, ".no_regnt"}, int'(bus.Gnt0 | bus.Gnt1), 0);
        chk({nm, ".wr_count"}, wr_cnt - w0, int'(wr));
    endtask

    initial begin
        int d0, w0;
        bus.Req0 = 0; bus.Wr0 = 0; bus.Addr0 = 0; bus.Wdata0 = 0;
        bus.Req1 = 0; bus.Wr1 = 0; bus.Addr1 = 0; bus.Wdata1 = 0;
        exp_rd[0] = 4'h0; exp_rd[1] = 4'h0;

        vec[0] = '{0, 1'b1, 3'd3, 4'hA};   // write 3 <- A
        vec[1] = '{1, 1'b0, 3'd3, 4'hA};   // read back via port 1
        vec[2] = '{0, 1'b1, 3'd0, 4'h5};   // preload for the fairness run
        vec[3] = '{1, 1'b1, 3'd1, 4'h6};
        for (int i = 0; i < 8; i++) begin
            vec[4 + i].port  = i % 2;
            vec[4 + i].wr    = 1'b1;
            vec[4 + i].addr  = 3'(i);
            vec[4 + i].data  = 4'(8 + i);
            vec[12 + i].port = (i + 1) % 2;
            vec[12 + i].wr   = 1'b0;
            vec[12 + i].addr = 3'(i);
            vec[12 + i].data = 4'(8 + i);
        end

        // Reset state
        #3;
        chk("rst.rs_rw",   int'(bus.RS_RW), 1);
        chk("rst.rs_addr", int'(bus.RS_Address), 0);
        chk("rst.rs_din",  int'(bus.RS_Data_in), 0);
        chk("rst.gnt",     int'({bus.Gnt1, bus.Gnt0}), 0);
        chk("rst.done",    int'({bus.Done1, bus.Done0}), 0);
        chk("rst.rdata",   int'({bus.Rdata1, bus.Rdata0}), 0);
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b0;

        // Single write, single read, preload
        for (int i = 0; i < 4; i++) do_access($sformatf("vec%0d", i), vec[i].port, vec[i].wr, vec[i].addr, vec[i].data);

        // Both held high: grants alternate 0,1,0,1, one Done every 2 cycles
        d0 = done_cnt;
        @(negedge Clk);
        bus.Req0 = 1; bus.Wr0 = 0; bus.Addr0 = 3'd0;
        bus.Req1 = 1; bus.Wr1 = 0; bus.Addr1 = 3'd1;
        for (int k = 0; k < 4; k++) begin
            int e;
            e = k % 2;
            @(posedge Clk); #1;
            chk($sformatf("rr%0d.gnt", k), int'({bus.Gnt1, bus.Gnt0}), e ? 2 : 1);
            @(posedge Clk); #1;
            chk($sformatf("rr%0d.done", k), int'({bus.Done1, bus.Done0}), e ? 2 : 1);
            chk($sformatf("rr%0d.rdata", k), int'(e ? bus.Rdata1 : bus.Rdata0), e ? 6 : 5);
            if (k == 3) begin bus.Req0 = 0; bus.Req1 = 0; end
        end
        exp_rd[0] = 4'h5; exp_rd[1] = 4'h6;
        @(posedge Clk); #1;
        chk("rr.idle_gnt", int'(bus.Gnt0 | bus.Gnt1), 0);
        chk("rr.done_cnt", done_cnt - d0, 4);

        // All eight addresses written then read back via alternating ports
        for (int i = 4; i < 20; i++) do_access($sformatf("vec%0d", i), vec[i].port, vec[i].wr, vec[i].addr, vec[i].data);

        // Reset during ACC of a write, before its negedge
        do_access("pre7", 1, 1'b1, 3'd7, 4'h3);
        d0 = done_cnt; w0 = wr_cnt;
        @(negedge Clk);
        bus.Req0 = 1; bus.Wr0 = 1; bus.Addr0 = 3'd7; bus.Wdata0 = 4'hF;
        @(posedge Clk); #1;
        chk("mid.gnt",   int'(bus.Gnt0), 1);
        chk("mid.rw_lo", int'(bus.RS_RW), 0);
        Rst = 1'b1;
        #1;
        chk("mid.rw_hi",   int'(bus.RS_RW), 1);
        chk("mid.gnt_off", int'(bus.Gnt0 | bus.Gnt1), 0);
        chk("mid.rdata",   int'({bus.Rdata1, bus.Rdata0}), 0);
        bus.Req0 = 0;
        exp_rd[0] = 4'h0; exp_rd[1] = 4'h0;
        @(negedge Clk); @(negedge Clk);
        Rst = 1'b0;
        @(posedge Clk); #1;
        chk("mid.no_write", wr_cnt - w0, 0);
        chk("mid.no_done",  done_cnt - d0, 0);
        do_access("post7", 1, 1'b0, 3'd7, 4'h3);

        // Req dropped during ACC: access still completes once
        @(negedge Clk);
        bus.Req0 = 1; bus.Wr0 = 0; bus.Addr0 = 3'd0;
        @(posedge Clk); #1;
        chk("drop.gnt", int'(bus.Gnt0), 1);
        bus.Req0 = 0;
        @(posedge Clk); #1;
        chk("drop.done",  int'(bus.Done0), 1);
        chk("drop.rdata", int'(bus.Rdata0), 8);
        @(posedge Clk); #1;
        chk("drop.done_off", int'(bus.Done0 | bus.Done1), 0);
        chk("drop.no_gnt",   int'(bus.Gnt0 | bus.Gnt1), 0);
        @(posedge Clk); #1;
        chk("drop.still_idle", int'(bus.Gnt0 | bus.Gnt1 | bus.Done0 | bus.Done1), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
